cbrt_mul_seq: RTL and testbench

- Sequential, parametrised unit computing result = a × floor(∛b) for unsigned W-bit operands.
- Uses a start/busy handshake and adds a one-cycle done strobe.
- Generalises the fixed 8-bit cube-root multiplier to any operand width W ≥ 3, with fixed, width-derived latency.
- Sits as an arithmetic accelerator behind a simple controller that pulses start and waits on busy/done.

---
 rtl/cbrt_mul_pkg.sv | 31 +++
 rtl/icbrt_step.sv | 48 ++++
 rtl/cbrt_mul_seq.sv | 150 +++++++++++++++
 tb/tb_cbrt_mul_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cbrt_mul_pkg.sv
// Shared types and width helpers for the cube-root multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t       controller states IDLE / ROOT / MUL
//   root_width()  bits of floor(cbrt(x)) for a w-bit x, i.e. ceil(w/3)
//   res_width()   width of a * floor(cbrt(b)) for w-bit operands
//   cnt_width()   width of a down-counter that holds values 0..k-1
package cbrt_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROOT = 2'd1,
    MUL  = 2'd2
  } state_t;

  function automatic int root_width(input int w);
    return (w + 2) / 3;
  endfunction

  function automatic int res_width(input int w);
    return w + root_width(w);
  endfunction

  // A single-iteration counter still needs one bit to exist.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/icbrt_step.sv
// One digit-by-digit integer cube-root iteration (purely combinational).
// Latency: 0 cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   x       remaining radicand
//   y       partial root accumulated so far
//   s       bit position of the current radicand digit (3 * iteration index)
//   x_next  radicand after subtracting the accepted trial term
//   y_next  partial root with the new root bit appended
module icbrt_step
  import cbrt_mul_pkg::*;
#(
  parameter int W  = 8,
  parameter int K  = root_width(W),
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  x,
  input  logic [K-1:0]  y,
  input  logic [SW-1:0] s,
  output logic [W-1:0]  x_next,
  output logic [K-1:0]  y_next
);

  // Two guard bits above W: the trial term 3*y'*(y'+1)+1 can exceed the
  // shifted radicand by up to ~4x before the comparison rejects it.
  localparam int TW = W + 2;

  logic [TW-1:0] y2;
  logic [TW-1:0] t;
  logic [TW-1:0] x_sh;
  logic          take;

  always_comb begin
    y2     = TW'(y) << 1;
    t      = TW'(3) * y2 * (y2 + TW'(1)) + TW'(1);
    x_sh   = TW'(x >> s);
    take   = (x_sh >= t);
    x_next = x;
    y_next = y2[K-1:0];
    if (take) begin
      // take implies t <= x >> s, so t fits in W bits and t << s <= x.
      x_next = x - (t[W-1:0] << s);
      y_next = y2[K-1:0] + K'(1);
    end
  end

endmodule

// File: rtl/cbrt_mul_seq.sv
// Sequential result = a * floor(cbrt(b)) for unsigned W-bit operands.
// Latency: 2*K cycles from accepted start to done (K = ceil(W/3)); K root steps then K shift-add steps.
// Backpressure: start is only sampled in IDLE; a start while busy is dropped, not queued.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      request, accepted only while idle (including the done cycle)
//   a_i, b_i   multiplicand and radicand, captured on the accepting edge
//   result     last computed product, held until the next completion
//   busy       high while ROOT or MUL is running
//   done       one-cycle pulse in the cycle result updates
//
// Optional feature: define CBRT_MUL_EARLY_EXIT_EN to let zero operands
// finish on the next cycle without ever raising busy.
module cbrt_mul_seq
  import cbrt_mul_pkg::*;
#(
  parameter  int W     = 8,
  localparam int K     = root_width(W),
  localparam int RES_W = res_width(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(W);
  localparam int CW = cnt_width(K);
  localparam logic [CW-1:0] ITER_TOP = CW'(K - 1);

  state_t state;
  state_t state_nxt;

  logic [W-1:0]     a_r;
  logic [W-1:0]     x_r;
  logic [K-1:0]     y_r;
  logic [RES_W-1:0] acc_r;
  logic [CW-1:0]    iter;

  logic [SW-1:0]    s;
  logic [W-1:0]     x_step;
  logic [K-1:0]     y_step;
  logic [RES_W-1:0] acc_nxt;
  logic             last;
  logic             skip;

  assign last = (iter == '0);

`ifdef CBRT_MUL_EARLY_EXIT_EN
  // Either factor zero forces a zero product; no need to iterate.
  assign skip = (a_i == '0) || (b_i == '0);
`else
  assign skip = 1'b0;
`endif

  // Radicand digits are 3 bits wide, so digit iter starts at bit 3*iter.
  assign s = SW'(iter) * SW'(3);

  icbrt_step #(
    .W  (W),
    .K  (K),
    .SW (SW)
  ) u_step (
    .x      (x_r),
    .y      (y_r),
    .s      (s),
    .x_next (x_step),
    .y_next (y_step)
  );

  // MSB-first shift-add: one root bit per cycle.
  assign acc_nxt = (acc_r << 1) + (y_r[iter] ? RES_W'(a_r) : '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !skip) state_nxt = ROOT;
      ROOT: if (last)           state_nxt = MUL;
      MUL:  if (last)           state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: operand capture, root iteration, shift-add, result/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      acc_r  <= '0;
      iter   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (skip) begin
              result <= '0;
              done   <= 1'b1;
            end else begin
              a_r   <= a_i;
              x_r   <= b_i;
              y_r   <= '0;
              acc_r <= '0;
              iter  <= ITER_TOP;
            end
          end
        end
        ROOT: begin
          x_r  <= x_step;
          y_r  <= y_step;
          iter <= last ? ITER_TOP : iter - CW'(1);
        end
        MUL: begin
          acc_r <= acc_nxt;
          if (last) begin
            result <= acc_nxt;
            done   <= 1'b1;
          end else begin
            iter <= iter - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cbrt_mul_seq.sv
// Directed bench for cbrt_mul_seq at W=8 and W=16.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_cbrt_mul_seq;

`ifdef CBRT_MUL_EARLY_EXIT_EN
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_BUSY = 6;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [10:0] res8;
  logic [21:0] res16;
  logic        busy8, done8, busy16, done16;

  int tests = 0;
  int fails = 0;
  bit overlap;
  int bc_m;
  bit got_m;

  cbrt_mul_seq #(.W(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .a_i    (a8),
    .b_i    (b8),
    .result (res8),
    .busy   (busy8),
    .done   (done8)
  );

  cbrt_mul_seq #(.W(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .start  (start16),
    .a_i    (a16),
    .b_i    (b16),
    .result (res16),
    .busy   (busy16),
    .done   (done16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic get_done(input bit wide);
    return wide ? done16 : done8;
  endfunction

  function automatic logic [31:0] get_res(input bit wide);
    return wide ? 32'(res16) : 32'(res8);
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after the accepting edge.
  task automatic issue(input bit wide, input logic [15:0] a, input logic [15:0] b);
    if (wide) begin
      a16 = a; b16 = b; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  // Counts busy cycles until done is seen; stops at the negedge where done is high.
  task automatic wait_done(input bit wide, inout int bc, output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (get_busy(wide) && get_done(wide)) overlap = 1'b1;
      if (get_done(wide)) begin
        got = 1'b1;
        break;
      end
      if (get_busy(wide)) bc++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input bit wide, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp, input int exp_busy);
    int bc;
    bit got;
    bc = 0;
    overlap = 1'b0;
    issue(wide, a, b);
    wait_done(wide, bc, got);
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_res"}, get_res(wide), exp);
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    @(negedge clk);
    check({tag, "_single_pulse"}, 32'(get_done(wide)), 32'd0);
    check({tag, "_idle_after"}, 32'(get_busy(wide)), 32'd0);
    check({tag, "_no_overlap"}, 32'(overlap), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset_res8", get_res(0), 32'd0);
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_done8", 32'(done8), 32'd0);
    check("reset_res16", get_res(1), 32'd0);
    check("reset_busy16", 32'(busy16), 32'd0);
    check("reset_done16", 32'(done16), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic W=8 products.
    run("w8_5_27",   0, 16'd5,   16'd27,  32'd15,   6);
    run("w8_3_64",   0, 16'd3,   16'd64,  32'd12,   6);
    run("w8_255_200",0, 16'd255, 16'd200, 32'd1275, 6);
    run("w8_44_255", 0, 16'd44,  16'd255, 32'd264,  6);

    // Zero operands.
    run("w8_97_0",   0, 16'd97,  16'd0,   32'd0, ZERO_BUSY);
    run("w8_0_200",  0, 16'd0,   16'd200, 32'd0, ZERO_BUSY);

    // Start while busy is dropped; start in the done cycle is accepted.
    bc_m = 0;
    overlap = 1'b0;
    issue(0, 16'd9, 16'd125);
    repeat (2) begin
      if (busy8) bc_m++;
      @(negedge clk);
    end
    a8 = 8'd84; b8 = 8'd84; start8 = 1'b1;
    if (busy8) bc_m++;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(0, bc_m, got_m);
    check("busy_start_done", 32'(got_m), 32'd1);
    check("busy_start_res", get_res(0), 32'd45);
    check("busy_start_cycles", 32'(bc_m), 32'd6);
    bc_m = 0;
    issue(0, 16'd84, 16'd84);
    wait_done(0, bc_m, got_m);
    check("done_cycle_start_done", 32'(got_m), 32'd1);
    check("done_cycle_start_res", get_res(0), 32'd336);
    check("done_cycle_start_cycles", 32'(bc_m), 32'd6);
    check("done_cycle_no_overlap", 32'(overlap), 32'd0);
    @(negedge clk);

    // Reset in the middle of an operation.
    issue(0, 16'd255, 16'd200);
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_res", get_res(0), 32'd0);
    got_m = 1'b0;
    repeat (20) begin
      if (done8) got_m = 1'b1;
      @(negedge clk);
    end
    check("abort_no_late_done", 32'(got_m), 32'd0);
    run("w8_11_216", 0, 16'd11, 16'd216, 32'd66, 6);

    // Simultaneous rst and start: start is dropped.
    rst = 1'b1;
    a8 = 8'd5; b8 = 8'd27; start8 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start8 = 1'b0;
    check("rst_start_busy", 32'(busy8), 32'd0);
    check("rst_start_done", 32'(done8), 32'd0);
    @(negedge clk);
    check("rst_start_busy_later", 32'(busy8), 32'd0);
    check("rst_start_done_later", 32'(done8), 32'd0);

    // W=16 instance.
    run("w16_1000_65535",  1, 16'd1000,  16'd65535, 32'd40000,   12);
    run("w16_65535_64000", 1, 16'd65535, 16'd64000, 32'd2621400, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
